pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_data_reg.sv | 19 +
 rtl/pipe_skid_reg.sv | 114 +++++++++++
 tb/tb_pipe_skid_reg.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the skid-buffered pipeline register:
// state encoding and transfer counter width.
package pipe_pkg;

    localparam int XFER_W = 16;

    // Encoding doubles as the held-entry count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-wide data register with load enable and async clear.
module pipe_data_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with registered in_ready.
// Optional synchronous flush port enabled by PIPE_SKID_FLUSH_EN.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic              flush,
`endif
    output logic [1:0]        occupancy,
    output logic [XFER_W-1:0] xfer_count
);

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign out_valid = (state != ST_EMPTY);
    assign occupancy = state;

    always_comb begin
        state_n        = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_n   = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_ready) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    state_n   = ST_FULL;
                    load_skid = 1'b1;
                end else if (out_ready) begin
                    state_n = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    state_n        = ST_ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_n = ST_EMPTY;
        endcase
`ifdef PIPE_SKID_FLUSH_EN
        if (flush) begin
            state_n        = ST_EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
`endif
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_n;
            in_ready <= (state_n != ST_FULL);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            xfer_count <= '0;
        else if (out_xfer)
            xfer_count <= xfer_count + XFER_W'(1);
    end

    pipe_data_reg #(.WIDTH(WIDTH)) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_main),
        .d       (main_d),
        .q       (out_data)
    );

    pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_skid),
        .d       (in_data),
        .q       (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: queue-based reference model,
// per-cycle compare, and directed literal checks.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  occupancy;
    logic [15:0] xfer_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(64)) dut (
        .clk        (clk),
        .reset_n    (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef PIPE_SKID_FLUSH_EN
        .flush      (flush),
`endif
        .occupancy  (occupancy),
        .xfer_count (xfer_count)
    );

    // Reference model: a FIFO of held entries plus registered ready.
    logic [63:0] mq[$];
    logic [63:0] m_last = '0;
    logic        m_rdy  = 1'b0;
    logic [15:0] m_cnt  = '0;

    always @(posedge clk or negedge rst_n) begin
        logic ixf;
        logic oxf;
        logic fl;
        if (!rst_n) begin
            mq.delete();
            m_last = '0;
            m_rdy  = 1'b0;
            m_cnt  = '0;
        end else begin
            ixf = in_valid & m_rdy;
            oxf = (mq.size() > 0) & out_ready;
`ifdef PIPE_SKID_FLUSH_EN
            fl = flush;
`else
            fl = 1'b0;
`endif
            if (oxf) m_cnt = m_cnt + 16'd1;
            if (fl) begin
                mq.delete();
            end else begin
                if (oxf) void'(mq.pop_front());
                if (ixf) mq.push_back(in_data);
            end
            if (mq.size() > 0) m_last = mq[0];
            m_rdy = (mq.size() < 2);
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("cyc_out_data", out_data, m_last);
        chk("cyc_in_ready", 64'(in_ready), 64'(m_rdy));
        chk("cyc_occupancy", 64'(occupancy), 64'(mq.size()));
        chk("cyc_xfer_count", 64'(xfer_count), 64'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_xfer_count", 64'(xfer_count), 64'd0);
        do_reset();
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // Single beat
        in_valid = 1'b1;
        in_data  = 64'hA5;
        out_ready = 1'b1;
        tick();
        chk("beat_out_valid", 64'(out_valid), 64'd1);
        chk("beat_out_data", out_data, 64'hA5);
        in_valid = 1'b0;
        tick();
        chk("beat_xfer_count", 64'(xfer_count), 64'd1);
        chk("beat_drained", 64'(out_valid), 64'd0);

        // Back-pressure fills skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'd1;
        tick();
        in_data = 64'd2;
        tick();
        in_valid = 1'b0;
        chk("full_occupancy", 64'(occupancy), 64'd2);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_head", out_data, 64'd1);
        tick();
        chk("held_head", out_data, 64'd1);
        out_ready = 1'b1;
        tick();
        chk("drain_second", out_data, 64'd2);
        chk("drain_occ", 64'(occupancy), 64'd1);
        tick();
        chk("drain_empty", 64'(out_valid), 64'd0);
        chk("drain_count", 64'(xfer_count), 64'd3);

        // Streaming 100 beats
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(1000 + i);
            tick();
            chk("stream_ready", 64'(in_ready), 64'd1);
            chk("stream_data", out_data, 64'(1000 + i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_count", 64'(xfer_count), 64'd103);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom(), $urandom()};
`ifdef PIPE_SKID_FLUSH_EN
            flush = ($urandom_range(0, 19) == 0);
`endif
            tick();
        end
        flush = 1'b0;

`ifdef PIPE_SKID_FLUSH_EN
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h11;
        tick();
        in_data = 64'h22;
        tick();
        chk("pre_flush_occ", 64'(occupancy), 64'd2);
        in_data = 64'h33;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
`endif

        // Async reset mid-stream
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 64'hBEEF;
        tick();
        tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_data", out_data, 64'd0);
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd0);
        chk("async_occ", 64'(occupancy), 64'd0);
        chk("async_count", 64'(xfer_count), 64'd0);
        @(negedge clk);
        do_reset();

        // Counter wrap after 65536 transfers
        out_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
        tick();
        end
        chk("pre_wrap_count", 64'(xfer_count), 64'hFFFF);
        in_valid = 1'b0;
        tick();
        chk("wrap_count", 64'(xfer_count), 64'd0);
        chk("wrap_data", out_data, 64'hFFFF);
        chk("wrap_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
